// File: rtl/cpu_defs_pkg.sv
// Shared multicycle CPU definitions: states, opcodes, control encodings.
// Used by the control FSM and the branch-decision logic.
package cpu_defs;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC      = 4'd2,
    S_ALU_WB    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WB    = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_HALT      = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE, C_IMM, C_BR, C_JMP,
    C_LD, C_ST, C_HALT, C_ILL
  } opclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [3:0] OP_IMM_HI = 4'b0001;
  localparam logic [3:0] OP_BR_HI = 4'b1000;
  localparam logic [5:0] OP_BEQ = 6'b100000;
  localparam logic [5:0] OP_BNE = 6'b100001;
  localparam logic [5:0] OP_BLT = 6'b100010;
  localparam logic [5:0] OP_BLE = 6'b100011;
  localparam logic [5:0] OP_J = 6'b100100;
  localparam logic [5:0] OP_LW = 6'b110000;
  localparam logic [5:0] OP_SW = 6'b110001;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       branch_ctl;
    logic       halted;
  } ctl_t;

  function automatic ctl_t ctl_of(state_t s, opclass_t c);
    ctl_t k;
    k = '0;
    case (s)
      S_FETCH: begin
        k.mem_read = 1'b1;
        k.alu_src_b = SRCB_FOUR;
        k.alu_op = ALUOP_ADD;
        k.pc_src = PCSRC_ALU;
      end
      S_DECODE: begin
        k.alu_src_b = SRCB_IMMSH;
        k.alu_op = ALUOP_ADD;
      end
      S_EXEC: begin
        k.alu_src_a = 1'b1;
        if (c == C_RTYPE) begin
          k.alu_src_b = SRCB_REGB;
          k.alu_op = ALUOP_FUNCT;
        end else begin
          k.alu_src_b = SRCB_IMM;
          k.alu_op = ALUOP_IMM;
        end
      end
      S_ALU_WB: begin
        k.reg_write = 1'b1;
        k.reg_dst = (c == C_RTYPE);
      end
      S_MEM_ADDR: begin
        k.alu_src_a = 1'b1;
        k.alu_src_b = SRCB_IMM;
        k.alu_op = ALUOP_ADD;
      end
      S_MEM_READ: begin
        k.iord = 1'b1;
        k.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        k.reg_write = 1'b1;
        k.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        k.iord = 1'b1;
        k.mem_write = 1'b1;
      end
      S_BRANCH: begin
        k.alu_src_a = 1'b1;
        k.alu_src_b = SRCB_REGB;
        k.alu_op = ALUOP_SUB;
        k.pc_src = PCSRC_ALUOUT;
        k.pc_write_cond = 1'b1;
        k.branch_ctl = 1'b1;
      end
      S_JUMP: begin
        k.pc_src = PCSRC_JUMP;
        k.pc_write = 1'b1;
      end
      S_HALT: k.halted = 1'b1;
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/mcctl_opclass.sv
// Opcode classifier for the multicycle control FSM.
// Pure combinational: IR opcode field -> instruction class.
module mcctl_opclass
  import cpu_defs::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  output opclass_t            o_cls
);

  logic [3:0] w_hi;
  assign w_hi = i_opcode[OPCODE_W-1 -: 4];

  // Map opcode onto its class; unknown codes are illegal.
  always_comb begin
    o_cls = C_ILL;
    unique case (1'b1)
      (i_opcode == OP_RTYPE): o_cls = C_RTYPE;
      (w_hi == OP_IMM_HI):    o_cls = C_IMM;
      (w_hi == OP_BR_HI):     o_cls = C_BR;
      (i_opcode == OP_J):     o_cls = C_JMP;
      (i_opcode == OP_LW):    o_cls = C_LD;
      (i_opcode == OP_SW):    o_cls = C_ST;
      (i_opcode == OP_HALT):  o_cls = C_HALT;
      default:                o_cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle CPU (registered Moore outputs).
// Option MCCTL_PERF_EN adds instr_count/cycle_count counters.
module multicycle_control
  import cpu_defs::*;
#(
  parameter int OPCODE_W = 6
`ifdef MCCTL_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                ir_write,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                branch_ctl,
  output logic                halted,
  output logic                illegal_op
`ifdef MCCTL_PERF_EN
  ,
  output logic [CNT_W-1:0]    instr_count,
  output logic [CNT_W-1:0]    cycle_count
`endif
);

  state_t   r_state;
  ctl_t     r_ctl;
  opclass_t r_cls;
  logic     r_illegal;

  state_t   w_nxt;
  opclass_t w_cls;
  opclass_t w_cls_use;
  logic     w_fetch_done;

  mcctl_opclass #(
    .OPCODE_W(OPCODE_W)
  ) u_opclass (
    .i_opcode(opcode),
    .o_cls   (w_cls)
  );

  // A fetch only completes once the read request is actually out,
  // so the idle cycle after reset cannot consume a stray mem_ready.
  assign w_fetch_done = (r_state == S_FETCH) & r_ctl.mem_read
                        & mem_ready;

  // Opcode class: live in DECODE, latched copy afterwards.
  assign w_cls_use = (r_state == S_DECODE) ? w_cls : r_cls;

  // Next-state selection.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_FETCH:
        if (w_fetch_done) w_nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (w_cls == C_RTYPE),
          (w_cls == C_IMM):  w_nxt = S_EXEC;
          (w_cls == C_BR):   w_nxt = S_BRANCH;
          (w_cls == C_JMP):  w_nxt = S_JUMP;
          (w_cls == C_LD),
          (w_cls == C_ST):   w_nxt = S_MEM_ADDR;
          default:           w_nxt = S_HALT;
        endcase
      end
      S_EXEC:      w_nxt = S_ALU_WB;
      S_ALU_WB:    w_nxt = S_FETCH;
      S_MEM_ADDR:
        w_nxt = (r_cls == C_LD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:
        if (mem_ready) w_nxt = S_MEM_WB;
      S_MEM_WB:    w_nxt = S_FETCH;
      S_MEM_WRITE:
        if (mem_ready) w_nxt = S_FETCH;
      S_BRANCH:    w_nxt = S_FETCH;
      S_JUMP:      w_nxt = S_FETCH;
      S_HALT:      w_nxt = S_HALT;
      default:     w_nxt = S_FETCH;
    endcase
  end

  // State, registered control outputs, latched class, sticky illegal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_ctl     <= '0;
      r_cls     <= C_ILL;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_ctl   <= ctl_of(w_nxt, w_cls_use);
      if (r_state == S_DECODE) begin
        r_cls <= w_cls;
        if (w_cls == C_ILL) r_illegal <= 1'b1;
      end
    end
  end

  assign ir_write      = w_fetch_done;
  assign pc_write      = r_ctl.pc_write | w_fetch_done;
  assign iord          = r_ctl.iord;
  assign mem_read      = r_ctl.mem_read;
  assign mem_write     = r_ctl.mem_write;
  assign pc_write_cond = r_ctl.pc_write_cond;
  assign pc_src        = r_ctl.pc_src;
  assign alu_src_a     = r_ctl.alu_src_a;
  assign alu_src_b     = r_ctl.alu_src_b;
  assign alu_op        = r_ctl.alu_op;
  assign reg_write     = r_ctl.reg_write;
  assign mem_to_reg    = r_ctl.mem_to_reg;
  assign reg_dst       = r_ctl.reg_dst;
  assign branch_ctl    = r_ctl.branch_ctl;
  assign halted        = r_ctl.halted;
  assign illegal_op    = r_illegal;

`ifdef MCCTL_PERF_EN
  logic [CNT_W-1:0] r_instr_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;

  // Retire on every return to FETCH; count all non-HALT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
      r_cycle_cnt <= '0;
    end else begin
      if (r_state != S_FETCH && w_nxt == S_FETCH)
        r_instr_cnt <= r_instr_cnt + 1'b1;
      if (r_state != S_HALT)
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
    end
  end

  assign instr_count = r_instr_cnt;
  assign cycle_count = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
// Output bundle compared per cycle against hand-built vectors.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_ready;
  logic [5:0] opcode;
  logic       ir_write, iord, mem_read, mem_write;
  logic       pc_write, pc_write_cond;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       reg_write, mem_to_reg, reg_dst;
  logic       branch_ctl, halted, illegal_op;
`ifdef MCCTL_PERF_EN
  logic [31:0] instr_count, cycle_count;
`endif

  multicycle_control #(
    .OPCODE_W(6)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .ir_write     (ir_write),
    .iord         (iord),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .branch_ctl   (branch_ctl),
    .halted       (halted),
    .illegal_op   (illegal_op)
`ifdef MCCTL_PERF_EN
    ,
    .instr_count  (instr_count),
    .cycle_count  (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [18:0] obs;
  assign obs = {ir_write, iord, mem_read, mem_write,
                pc_write, pc_write_cond, pc_src,
                alu_src_a, alu_src_b, alu_op,
                reg_write, mem_to_reg, reg_dst,
                branch_ctl, halted, illegal_op};

  function automatic logic [18:0] v(
    input logic ir, io, mrd, mwr, pcw, pcwc,
    input logic [1:0] pcs,
    input logic asa,
    input logic [1:0] asb, aop,
    input logic rw, m2r, rd, bc, hl, il);
    return {ir, io, mrd, mwr, pcw, pcwc, pcs,
            asa, asb, aop, rw, m2r, rd, bc, hl, il};
  endfunction

  task automatic chk(input string tag,
                     input logic [18:0] got,
                     input logic [18:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tc(input string tag, input logic [18:0] exp);
    @(posedge clk);
    #1;
    chk(tag, obs, exp);
  endtask

  logic [18:0] Z, E_FETCH, E_FRDY, E_DEC, E_BR, E_JMP;
  logic [18:0] E_EXR, E_EXI, E_WBR, E_WBI, E_MADR;
  logic [18:0] E_MRD, E_MWB, E_MWR, E_HLT, E_HILL;

  initial begin
    Z      = '0;
    E_FETCH = v(0,0,1,0,0,0,2'b00,0,2'b01,2'b00,0,0,0,0,0,0);
    E_FRDY  = v(1,0,1,0,1,0,2'b00,0,2'b01,2'b00,0,0,0,0,0,0);
    E_DEC   = v(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,0,0,0);
    E_BR    = v(0,0,0,0,0,1,2'b01,1,2'b00,2'b01,0,0,0,1,0,0);
    E_JMP   = v(0,0,0,0,1,0,2'b10,0,2'b00,2'b00,0,0,0,0,0,0);
    E_EXR   = v(0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0,0,0,0);
    E_EXI   = v(0,0,0,0,0,0,2'b00,1,2'b10,2'b11,0,0,0,0,0,0);
    E_WBR   = v(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1,0,0,0);
    E_WBI   = v(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,0,0,0,0);
    E_MADR  = v(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0,0,0);
    E_MRD   = v(0,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0,0);
    E_MWB   = v(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,1,0,0,0,0);
    E_MWR   = v(0,1,0,1,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0,0);
    E_HLT   = v(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,1,0);
    E_HILL  = v(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,1,1);

    rst_n = 1'b0;
    mem_ready = 1'b0;
    opcode = 6'b000000;
    #1 chk("rst_outs", obs, Z);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rel_idle", obs, Z);
    tc("fetch_wait", E_FETCH);

    rst_n = 1'b0;
    #1 chk("rst_mid", obs, Z);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tc("refetch", E_FETCH);
    tc("fetch_hold", E_FETCH);

    opcode = 6'b100000;
    mem_ready = 1'b1;
    #1 chk("beq_f", obs, E_FRDY);
    tc("beq_d", E_DEC);
    tc("beq_b", E_BR);
    tc("beq_ret", E_FRDY);

    opcode = 6'b110000;
    tc("lw_d", E_DEC);
    tc("lw_a", E_MADR);
    mem_ready = 1'b0;
    tc("lw_r1", E_MRD);
    tc("lw_r2", E_MRD);
    tc("lw_r3", E_MRD);
    tc("lw_r4", E_MRD);
    mem_ready = 1'b1;
    tc("lw_wb", E_MWB);
    tc("lw_ret", E_FRDY);

    opcode = 6'b110001;
    tc("sw_d", E_DEC);
    tc("sw_a", E_MADR);
    tc("sw_w", E_MWR);
    tc("sw_ret", E_FRDY);
    opcode = 6'b000000;
    tc("r_d", E_DEC);
    tc("r_e", E_EXR);
    tc("r_wb", E_WBR);
    tc("r_ret", E_FRDY);

    opcode = 6'b000110;
    tc("i_d", E_DEC);
    tc("i_e", E_EXI);
    tc("i_wb", E_WBI);
    tc("i_ret", E_FRDY);

    opcode = 6'b100100;
    tc("j_d", E_DEC);
    tc("j_j", E_JMP);
    tc("j_ret", E_FRDY);

    opcode = 6'b101010;
    tc("ill_d", E_DEC);
    tc("ill_h", E_HILL);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      tc("halt_hold", E_HILL);
    end

    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'b111111;
    #1 chk("rst_halt", obs, Z);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tc("h_f", E_FRDY);
    tc("h_d", E_DEC);
    tc("h_h", E_HLT);
    tc("h_hold", E_HLT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
